uart_bus_arbiter: RTL
=====================

Name: uart_bus_arbiter

Overview:
- Two-master, one-slave round-robin arbiter on the native memory bus (mem_valid/mem_ready, mem_addr, mem_wstrb, mem_wdata, mem_rdata).
- Lets the CPU (master 0) and a second requester (master 1, e.g. a debug/DMA engine) share one uart peripheral instance.
- Sits between the two masters and the uart slave port; serialises transactions one at a time.
- An optional watchdog completes transactions the slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 1024, slave-stall limit in clk cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_mem_valid  input  1  master 0 request.
- m0_mem_addr  input  32  master 0 address.
- m0_mem_wstrb  input  4  master 0 byte strobes; 0 = read.
- m0_mem_wdata  input  32  master 0 write data.
- m0_mem_rdata  output  32  master 0 read data.
- m0_mem_ready  output  1  master 0 completion pulse.
- m1_mem_valid, m1_mem_addr, m1_mem_wstrb, m1_mem_wdata, m1_mem_rdata, m1_mem_ready: same as m0_*, for master 1.
- s_mem_valid  output  1  request to slave.
- s_mem_addr  output  32  slave address.
- s_mem_wstrb  output  4  slave strobes.
- s_mem_wdata  output  32  slave write data.
- s_mem_rdata  input  32  slave read data.
- s_mem_ready  input  1  slave completion.
- grant  output  1  index of the master owning the bus; valid when busy = 1.
- busy  output  1  1 while in state BUSY.
- timeout_err  output  1  one-cycle pulse on watchdog completion.

Behaviour:
- Bus protocol: a master holds valid/addr/wstrb/wdata stable until it sees ready = 1 for one cycle; it may re-assert valid no earlier than the next cycle.
- State register: IDLE, BUSY. Further registers: grant (1 bit), last (1 bit, last master served).
- Reset (synchronous, active-high):
  - state = IDLE, grant = 0, last = 1, so master 0 wins the first tie.
  - Timeout counter = 0.
  - All outputs are 0 in the cycle after reset: s_mem_valid, m0/m1_mem_ready, m0/m1_mem_rdata, s_mem_addr/wstrb/wdata, busy, timeout_err.
- IDLE:
  - Neither master valid: stay in IDLE.
  - One master valid: grant it, go to BUSY.
  - Both valid: grant the master != last.
- BUSY:
  - s_mem_valid = granted master's valid.
  - s_mem_addr, s_mem_wstrb and s_mem_wdata are muxed combinationally from the granted master.
  - Arbitration latency: the request reaches the slave 1 cycle after valid rises (IDLE→BUSY edge).
- Completion, BUSY with s_mem_ready = 1:
  - mX_mem_ready = 1 for the granted X only, in the same cycle as s_mem_ready.
  - mX_mem_rdata = s_mem_rdata in that cycle.
  - last = grant; go to IDLE.
- Non-granted master: ready and rdata held at 0 at all times.
- Turnaround: at least one IDLE cycle between consecutive transactions; no back-to-back grant.
- Abort: granted master drops valid in BUSY with no s_mem_ready → go to IDLE; no ready is issued and last is unchanged.
- Outside BUSY: s_mem_valid = 0 and s_mem_addr/wstrb/wdata = 0.
- s_mem_ready while not BUSY: ignored.
- Reset mid-transaction: state goes to IDLE next cycle and s_mem_valid drops immediately after the reset edge. The transaction is lost and the slave is expected to be reset together with the arbiter.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1…

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with s_mem_ready = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with no s_mem_ready, the arbiter completes the transaction itself:
    - mX_mem_ready = 1 and mX_mem_rdata = TIMEOUT_RDATA for that cycle.
    - timeout_err = 1 for that cycle.
    - s_mem_valid = 0 from the next cycle; last = grant; state = IDLE.
  - s_mem_ready arriving in the same cycle as the timeout wins: normal completion, timeout_err = 0.
- Not defined: no counter is built, BUSY waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Single write: m0 writes wdata 0x0000_00CE, wstrb 4'b1111 to addr 0x0000_0004 → s_mem_valid high 1 cycle after m0_mem_valid with identical addr/data; m0_mem_ready pulses with s_mem_ready; grant = 0.
- Simultaneous requests after reset: m0 and m1 both write to 0x4 (data 0x01 and 0x02) → m0 served first, then ≥1 IDLE cycle, then m1; the slave sees 0x01 then 0x02.
- Continuous contention: 6 back-to-back requests from each master → grant sequence 0,1,0,1,… exactly; no master is served twice in a row.
- Read path: m1 reads addr 0x0, slave returns s_mem_rdata 0x0000_0023 → m1_mem_rdata = 0x23 in the ready cycle; m0_mem_rdata and m0_mem_ready stay 0.
- Reset in BUSY: assert reset while m0 is granted and the slave has not responded → next cycle state IDLE and s_mem_valid = 0; after reset release with both masters requesting, m0 is granted first.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8: slave never asserts ready → after 8 BUSY cycles, m0_mem_ready = 1, m0_mem_rdata = 0xDEAD_BEEF and timeout_err = 1 for 1 cycle; the next m0 request is granted normally.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single native-bus uart slave.
// Define ARB_TIMEOUT_EN to build the slave-stall watchdog (TIMEOUT_CYCLES / TIMEOUT_RDATA).
module uart_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_mem_valid,
  input  logic [31:0] m0_mem_addr,
  input  logic [3:0]  m0_mem_wstrb,
  input  logic [31:0] m0_mem_wdata,
  output logic [31:0] m0_mem_rdata,
  output logic        m0_mem_ready,

  input  logic        m1_mem_valid,
  input  logic [31:0] m1_mem_addr,
  input  logic [3:0]  m1_mem_wstrb,
  input  logic [31:0] m1_mem_wdata,
  output logic [31:0] m1_mem_rdata,
  output logic        m1_mem_ready,

  output logic        s_mem_valid,
  output logic [31:0] s_mem_addr,
  output logic [3:0]  s_mem_wstrb,
  output logic [31:0] s_mem_wdata,
  input  logic [31:0] s_mem_rdata,
  input  logic        s_mem_ready,

  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_grant;
  logic        w_grant_nx;
  logic        r_last;
  logic        w_last_nx;

  logic        w_busy;
  logic        w_sel_valid;
  logic [31:0] w_sel_addr;
  logic [3:0]  w_sel_wstrb;
  logic [31:0] w_sel_wdata;
  logic        w_timeout;
  logic        w_complete;
  logic [31:0] w_done_rdata;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  assign w_busy = (r_state == BUSY);

  always_comb begin
    w_sel_valid = m0_mem_valid;
    w_sel_addr  = m0_mem_addr;
    w_sel_wstrb = m0_mem_wstrb;
    w_sel_wdata = m0_mem_wdata;
    if (r_grant) begin
      w_sel_valid = m1_mem_valid;
      w_sel_addr  = m1_mem_addr;
      w_sel_wstrb = m1_mem_wstrb;
      w_sel_wdata = m1_mem_wdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;

  // Held at zero while IDLE so every BUSY entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (!w_busy) begin
      r_to_cnt <= '0;
    end else if (!s_mem_ready) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign w_timeout = w_busy && w_sel_valid && !s_mem_ready && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_last  <= w_last_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_last_nx  = r_last;
    unique case (r_state)
      IDLE: begin
        if (m0_mem_valid || m1_mem_valid) begin
          w_state_nx = BUSY;
          // On a tie the master not served last wins; otherwise the lone requester.
          w_grant_nx = (m0_mem_valid && m1_mem_valid) ? ~r_last : m1_mem_valid;
        end
      end
      BUSY: begin
        if (s_mem_ready || w_timeout) begin
          w_state_nx = IDLE;
          w_last_nx  = r_grant;
        end else if (!w_sel_valid) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_complete   = w_busy && (s_mem_ready || w_timeout);
  assign w_done_rdata = w_timeout ? TIMEOUT_RDATA : s_mem_rdata;

  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wstrb  = '0;
    s_mem_wdata  = '0;
    m0_mem_ready = 1'b0;
    m1_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_rdata = '0;
    if (w_busy) begin
      s_mem_valid = w_sel_valid;
      s_mem_addr  = w_sel_addr;
      s_mem_wstrb = w_sel_wstrb;
      s_mem_wdata = w_sel_wdata;
    end
    if (w_complete) begin
      if (r_grant) begin
        m1_mem_ready = 1'b1;
        m1_mem_rdata = w_done_rdata;
      end else begin
        m0_mem_ready = 1'b1;
        m0_mem_rdata = w_done_rdata;
      end
    end
  end

  assign grant       = r_grant;
  assign busy        = w_busy;
  assign timeout_err = w_timeout;

endmodule
